// File: rtl/phase_acc_if.sv
// Shadow-register write bus for phase_acc_bank: per-channel writes, commit strobe, pending status.
interface phase_acc_if #(
  parameter int unsigned CHW = 2,
  parameter int unsigned PW  = 19
);
  logic           wr_en;
  logic [1:0]     wr_sel;
  logic [CHW-1:0] wr_ch;
  logic [PW-1:0]  wr_data;
  logic           commit;
  logic           pending;

  modport master (output wr_en, wr_sel, wr_ch, wr_data, commit, input pending);
  modport slave  (input wr_en, wr_sel, wr_ch, wr_data, commit, output pending);
endinterface

// File: rtl/phase_acc_bank.sv
// Multi-channel NCO phase-accumulator bank with double-buffered increment/offset/mode registers.
// Optional output dither (LFSR low bits added to phase) enabled by defining PHASE_DITHER_EN.
module phase_acc_bank #(
  parameter int unsigned NCH = 4,
  parameter int unsigned CHW = 2,
  parameter int unsigned PW  = 19,
  parameter int unsigned DW  = 4
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              ce_slow,
  input  logic              phase_sync,
  phase_acc_if.slave        cfg,
  output logic [NCH*PW-1:0] phase_out,
  output logic [NCH*PW-1:0] phase_inv_out,
  output logic [NCH-1:0]    phase_stb,
  output logic [NCH-1:0]    wrap
);

  localparam logic [1:0] SEL_INC  = 2'd0;
  localparam logic [1:0] SEL_OFF  = 2'd1;
  localparam logic [1:0] SEL_MODE = 2'd2;

  logic          wr_ok;
  logic          pending_q;
  logic [DW-1:0] dither;

  assign wr_ok       = cfg.wr_en && (cfg.wr_sel != 2'd3) && (32'(cfg.wr_ch) < NCH);
  assign cfg.pending = pending_q;

  // A write in the commit cycle lands in shadow after the copy, so pending stays set.
  always_ff @(posedge sys_clk) begin
    if (!rst_n)         pending_q <= 1'b0;
    else if (wr_ok)     pending_q <= 1'b1;
    else if (cfg.commit) pending_q <= 1'b0;
  end

`ifdef PHASE_DITHER_EN
  logic [15:0] lfsr;

  // Fibonacci LFSR, taps 16,14,13,11
  always_ff @(posedge sys_clk) begin
    if (!rst_n) lfsr <= 16'hACE1;
    else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  assign dither = lfsr[DW-1:0];
`else
  assign dither = '0;
`endif

  for (genvar k = 0; k < int'(NCH); k++) begin : g_ch
    localparam int unsigned CH = k;

    logic [PW-1:0] acc, sh_inc, sh_off, act_inc, act_off, ph, ph_q, inv_q;
    logic [1:0]    sh_mode, act_mode;
    logic [PW:0]   sum;
    logic          adv, stb_q, wrap_q, wr_here;

    always_comb begin
      adv     = !act_mode[1] && (!act_mode[0] || ce_slow);
      sum     = {1'b0, acc} + {1'b0, act_inc};
      ph      = acc + act_off + PW'(dither);
      wr_here = wr_ok && (cfg.wr_ch == CHW'(CH));
    end

    always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
        acc      <= '0;
        sh_inc   <= '0;
        sh_off   <= '0;
        sh_mode  <= '0;
        act_inc  <= '0;
        act_off  <= '0;
        act_mode <= '0;
        ph_q     <= '0;
        inv_q    <= '0;
        stb_q    <= 1'b0;
        wrap_q   <= 1'b0;
      end else begin
        // phase_sync overrides both advance and hold
        if (phase_sync) begin
          acc    <= '0;
          stb_q  <= 1'b0;
          wrap_q <= 1'b0;
        end else if (adv) begin
          acc    <= sum[PW-1:0];
          stb_q  <= 1'b1;
          wrap_q <= sum[PW];
        end else begin
          stb_q  <= 1'b0;
          wrap_q <= 1'b0;
        end
        ph_q  <= ph;
        inv_q <= -ph;
        if (cfg.commit) begin
          act_inc  <= sh_inc;
          act_off  <= sh_off;
          act_mode <= sh_mode;
        end
        if (wr_here) begin
          case (cfg.wr_sel)
            SEL_INC:  sh_inc  <= cfg.wr_data;
            SEL_OFF:  sh_off  <= cfg.wr_data;
            SEL_MODE: sh_mode <= cfg.wr_data[1:0];
            default:  ;
          endcase
        end
      end
    end

    assign phase_out[k*PW +: PW]     = ph_q;
    assign phase_inv_out[k*PW +: PW] = inv_q;
    assign phase_stb[k]              = stb_q;
    assign wrap[k]                   = wrap_q;
  end

endmodule

// File: tb/tb_phase_acc_bank.sv
// Self-checking bench for phase_acc_bank: directed scenarios then random traffic vs. a reference model.
module tb_phase_acc_bank;

  localparam int unsigned NCH  = 4;
  localparam int unsigned CHW  = 3;
  localparam int unsigned PW   = 19;
  localparam int unsigned DW   = 4;
  localparam int unsigned MASK = (1 << PW) - 1;

  logic              sys_clk = 1'b0;
  logic              rst_n, ce_slow, phase_sync;
  logic [NCH*PW-1:0] phase_out, phase_inv_out;
  logic [NCH-1:0]    phase_stb, wrap;

  int n_tests = 0;
  int n_fail  = 0;

  phase_acc_if #(.CHW(CHW), .PW(PW)) cfg_if ();

  phase_acc_bank #(.NCH(NCH), .CHW(CHW), .PW(PW), .DW(DW)) dut (
    .sys_clk       (sys_clk),
    .rst_n         (rst_n),
    .ce_slow       (ce_slow),
    .phase_sync    (phase_sync),
    .cfg           (cfg_if.slave),
    .phase_out     (phase_out),
    .phase_inv_out (phase_inv_out),
    .phase_stb     (phase_stb),
    .wrap          (wrap)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference model: architectural registers as plain integers
  int unsigned m_acc [NCH], m_sinc [NCH], m_ainc [NCH], m_soff [NCH], m_aoff [NCH];
  bit [1:0]    m_smode [NCH], m_amode [NCH];
  bit          m_pend;
  bit [15:0]   m_lfsr = 16'hACE1;
  int unsigned e_po [NCH], e_inv [NCH];
  bit          e_stb [NCH], e_wrap [NCH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    int unsigned s, dith;
    bit ok;
    if (!rst_n) begin
      for (int k = 0; k < NCH; k++) begin
        m_acc[k] = 0; m_sinc[k] = 0; m_ainc[k] = 0; m_soff[k] = 0; m_aoff[k] = 0;
        m_smode[k] = 0; m_amode[k] = 0;
        e_po[k] = 0; e_inv[k] = 0; e_stb[k] = 0; e_wrap[k] = 0;
      end
      m_pend = 0;
      m_lfsr = 16'hACE1;
      return;
    end
`ifdef PHASE_DITHER_EN
    dith = int'(m_lfsr) % (1 << DW);
`else
    dith = 0;
`endif
    for (int k = 0; k < NCH; k++) begin
      e_po[k]  = (m_acc[k] + m_aoff[k] + dith) & MASK;
      e_inv[k] = ((1 << PW) - e_po[k]) & MASK;
      if (phase_sync) begin
        m_acc[k] = 0; e_stb[k] = 0; e_wrap[k] = 0;
      end else if (!m_amode[k][1] && (!m_amode[k][0] || ce_slow)) begin
        s = m_acc[k] + m_ainc[k];
        e_wrap[k] = (s >> PW) != 0;
        m_acc[k]  = s & MASK;
        e_stb[k]  = 1;
      end else begin
        e_stb[k] = 0; e_wrap[k] = 0;
      end
    end
    if (cfg_if.commit)
      for (int k = 0; k < NCH; k++) begin
        m_ainc[k] = m_sinc[k]; m_aoff[k] = m_soff[k]; m_amode[k] = m_smode[k];
      end
    ok = cfg_if.wr_en && cfg_if.wr_sel != 3 && int'(cfg_if.wr_ch) < NCH;
    if (ok) begin
      case (cfg_if.wr_sel)
        2'd0: m_sinc[cfg_if.wr_ch]  = cfg_if.wr_data;
        2'd1: m_soff[cfg_if.wr_ch]  = cfg_if.wr_data;
        2'd2: m_smode[cfg_if.wr_ch] = cfg_if.wr_data[1:0];
        default: ;
      endcase
      m_pend = 1;
    end else if (cfg_if.commit) m_pend = 0;
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  endtask

  task automatic check_all();
    for (int k = 0; k < NCH; k++) begin
      chk($sformatf("phase_out[%0d]", k),     32'(phase_out[k*PW +: PW]),     e_po[k]);
      chk($sformatf("phase_inv_out[%0d]", k), 32'(phase_inv_out[k*PW +: PW]), e_inv[k]);
      chk($sformatf("phase_stb[%0d]", k),     32'(phase_stb[k]),              32'(e_stb[k]));
      chk($sformatf("wrap[%0d]", k),          32'(wrap[k]),                   32'(e_wrap[k]));
    end
    chk("pending", 32'(cfg_if.pending), 32'(m_pend));
  endtask

  // One clock: inputs sampled at the edge, model advanced, outputs checked 1 time unit later
  task automatic drive(input bit we, input bit [1:0] sel, input bit [CHW-1:0] ch,
                       input bit [PW-1:0] d, input bit cm, input bit ce, input bit sy);
    cfg_if.wr_en = we; cfg_if.wr_sel = sel; cfg_if.wr_ch = ch; cfg_if.wr_data = d;
    cfg_if.commit = cm; ce_slow = ce; phase_sync = sy;
    @(posedge sys_clk);
    model_update();
    #1;
    check_all();
    cfg_if.wr_en = 0; cfg_if.wr_sel = 0; cfg_if.wr_ch = 0; cfg_if.wr_data = 0;
    cfg_if.commit = 0; ce_slow = 0; phase_sync = 0;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic int unsigned po(input int k);
    return int'(phase_out[k*PW +: PW]);
  endfunction

  initial begin
    int cnt;
    int unsigned a, b;
    rst_n = 0;
    cfg_if.wr_en = 0; cfg_if.wr_sel = 0; cfg_if.wr_ch = 0; cfg_if.wr_data = 0;
    cfg_if.commit = 0; ce_slow = 0; phase_sync = 0;
    idle(); idle();
    chk("reset_phase_out", 32'(phase_out[31:0]), 0);
    chk("reset_pending", 32'(cfg_if.pending), 0);
    rst_n = 1;

`ifdef PHASE_DITHER_EN
    for (int i = 0; i < 12; i++) begin
      idle();
      chk("dither_acc_zero", 32'(po(0) >> DW), 0);
    end
`endif

    // 1: ch0 inc=52429, commit, pending 1 -> 0, ramp on phase_out
    drive(1, 0, 0, 52429, 0, 0, 0);
    drive(1, 2, 0, 0, 0, 0, 0);
    chk("s1_pending_set", 32'(cfg_if.pending), 1);
    drive(0, 0, 0, 0, 1, 0, 0);
    chk("s1_pending_clr", 32'(cfg_if.pending), 0);
`ifndef PHASE_DITHER_EN
    idle(); chk("s1_po0_a", po(0), 0);
    idle(); chk("s1_po0_b", po(0), 52429);
    idle(); chk("s1_po0_c", po(0), 104858);
    chk("s1_stb0", 32'(phase_stb[0]), 1);
`endif

    // 2: ch1 inc=2^18 wraps every second cycle; then offset 1
    drive(1, 0, 1, 262144, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    idle();
    cnt = 0;
    for (int i = 0; i < 8; i++) begin idle(); cnt += int'(wrap[1]); end
    chk("s2_wrap_count", 32'(cnt), 4);
`ifndef PHASE_DITHER_EN
    drive(1, 1, 1, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    idle();
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      idle();
      if (po(1) == 262145) cnt++;
      chk("s2_inv1", 32'(phase_inv_out[PW +: PW]), po(1) == 262145 ? 262143 : 524287);
    end
    chk("s2_inv_hi_count", 32'(cnt), 3);
`endif

    // 3: ch2 decimated advance, then hold
    drive(1, 2, 2, 1, 0, 0, 0);
    drive(1, 0, 2, 1000, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    idle();
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      drive(0, 0, 0, 0, 0, (i % 10) == 9, 0);
      cnt += int'(phase_stb[2]);
    end
    chk("s3_stb2_count", 32'(cnt), 3);
    drive(1, 2, 2, 3, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    idle(); idle();
    a = po(2); cnt = 0;
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 0, 0, 0, (i % 10) == 0, 0);
      cnt += int'(phase_stb[2]);
    end
`ifndef PHASE_DITHER_EN
    chk("s3_hold_po2", po(2), a);
`endif
    chk("s3_hold_stb", 32'(cnt), 0);

    // 4: write+commit same cycle commits the old shadow
    drive(1, 0, 3, 5, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    idle();
    drive(1, 0, 3, 7, 1, 0, 0);
    chk("s4_pending_kept", 32'(cfg_if.pending), 1);
    idle(); a = po(3); idle(); b = po(3);
`ifndef PHASE_DITHER_EN
    chk("s4_step5", (b - a) & MASK, 5);
`endif
    drive(0, 0, 0, 0, 1, 0, 0);
    chk("s4_pending_clr", 32'(cfg_if.pending), 0);
    idle(); idle(); a = po(3); idle(); b = po(3);
`ifndef PHASE_DITHER_EN
    chk("s4_step7", (b - a) & MASK, 7);
`endif
    drive(1, 0, 5, 99, 0, 0, 0);
    chk("s4_bad_ch", 32'(cfg_if.pending), 0);
    drive(1, 3, 0, 99, 0, 0, 0);
    chk("s4_bad_sel", 32'(cfg_if.pending), 0);

    // 5: phase_sync with commit, then mid-run reset
    drive(1, 2, 2, 0, 0, 0, 0);
    drive(1, 0, 0, 1111, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("s5_stb_zero", 32'(phase_stb), 0);
    drive(0, 0, 0, 0, 1, 1, 1);
    chk("s5_stb_zero_c", 32'(phase_stb), 0);
    chk("s5_wrap_zero", 32'(wrap), 0);
    idle(); idle(); idle();
    drive(1, 0, 1, 4242, 0, 0, 0);
    rst_n = 0;
    idle();
    rst_n = 1;
    chk("s5_rst_po", 32'(phase_out[31:0]), 0);
    chk("s5_rst_inv", 32'(phase_inv_out[31:0]), 0);
    chk("s5_rst_flags", 32'({phase_stb, wrap}), 0);
    chk("s5_rst_pending", 32'(cfg_if.pending), 0);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      rst_n = ($urandom_range(0, 399) != 0);
      drive($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), CHW'($urandom_range(0, 7)),
            ($urandom_range(0, 3) == 0) ? PW'($urandom_range(0, 3)) : PW'($urandom),
            $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 49) == 0);
    end
    rst_n = 1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/phase_acc_bank.md
Name: phase_acc_bank

Overview:
Parametrised multi-channel NCO phase-accumulator bank. It replaces the separate hand-written NCO, downconversion and CPU accumulators in the uberclock datapath with one block.
- Phase increments and offsets are double-buffered, so a CPU update lands on all channels in the same cycle.
- Each channel either free-runs or advances only on the decimated strobe.
- Each channel provides a phase output and a negated phase output for the CORDIC up/down pairs.

Parameters:
NCH, 4, number of channels (1..16)
CHW, 2, channel-select width; must satisfy 2^CHW >= NCH
PW, 19, phase width in bits
DW, 4, dither width (used only with PHASE_DITHER_EN; 1..PW-1)

Ports:
sys_clk  in  1  single clock; all logic on rising edge
rst_n  in  1  synchronous reset, active-low
ce_slow  in  1  decimated-rate strobe (ce_down)
wr_en  in  1  shadow-register write strobe
wr_sel  in  2  0=increment, 1=offset, 2=mode, 3=reserved
wr_ch  in  CHW  target channel
wr_data  in  PW  write data; mode uses bits [1:0]
commit  in  1  copy all shadow registers to active registers
phase_sync  in  1  zero all accumulators
phase_out  out  NCH*PW  per-channel phase = acc+offset; ch k at [k*PW +: PW]
phase_inv_out  out  NCH*PW  per-channel two's-complement negation of phase_out
phase_stb  out  NCH  per-channel pulse: phase_out carries an advanced value
wrap  out  NCH  per-channel pulse on accumulator carry-out
pending  out  1  shadow holds uncommitted writes

Behaviour:
Reset (rst_n=0 at a clock edge) zeroes all of the following:
- acc, active/shadow increment, offset and mode registers
- phase_out, phase_inv_out, phase_stb, wrap, pending
- applies at any time, including mid-run; no partial commit survives

Shadow writes:
- wr_en=1 writes wr_data into the shadow register selected by wr_sel for channel wr_ch.
- wr_ch >= NCH: write ignored.
- wr_sel=3: write ignored.
- Any accepted write sets pending=1 on the next cycle.

Commit:
- commit=1: all active registers take the shadow values on the next edge; pending clears.
- Write and commit in the same cycle: active registers get the pre-write shadow values. The write lands in shadow and pending=1 afterwards.

Mode bits, per channel:
- bit0=0: advance every cycle. bit0=1: advance only when ce_slow=1.
- bit1=1: hold; the accumulator is frozen and bit0 is ignored.

Accumulator, per channel:
- When advancing: acc <= (acc + inc_active) mod 2^PW.
- wrap[k] is high for exactly one cycle following an advance that produced a carry-out.
- inc=0 while advancing: acc stays constant, phase_stb still pulses, wrap stays 0.

phase_sync:
- Forces acc=0 on all channels; overrides advance and hold.
- wrap=0 and phase_stb=0 for that update.
- phase_sync together with commit: both take effect (acc=0 and new active registers).

Output pipeline, 1-cycle registered latency:
- phase_out[k](t+1) = (acc[k](t) + offset_active[k](t)) mod 2^PW.
- phase_inv_out[k](t+1) = (2^PW - phase_out value) mod 2^PW; a zero phase negates to 0.
- phase_stb[k](t+1)=1 iff acc[k] advanced at edge t.
- An offset change takes effect on phase_out one cycle after commit, with no acc discontinuity.

Optional Feature:
Macro PHASE_DITHER_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) steps every cycle.
  - Its low DW bits are added to the phase_out sum before registering.
  - phase_inv_out negates the dithered value.
  - acc is never dithered.
- Not defined: no LFSR is present, and outputs are exact as described under Behaviour.

Test Plan:
All scenarios use NCH=4, PW=19, DW=4, macro off unless stated.
1. Reset; write ch0 inc=52429; commit; mode 0 → pending 1→0. Cycles after the commit edge give acc 0, 52429, 104858; phase_out shows the same sequence one cycle later; phase_stb[0]=1 each cycle.
2. ch1 inc=262144, free-run → wrap[1] pulses every 2nd cycle; phase_out[1] alternates 262144/0; ch1 offset=1 → phase_inv_out[1] alternates 262143/524287.
3. ch2 mode=1, inc=1000, ce_slow 1-in-10 → acc[2] steps by 1000 only on strobes; phase_stb[2] one cycle after each strobe. Then mode=3 → acc frozen despite ce_slow.
4. Write ch3 inc=7 and commit in the same cycle, shadow previously 5 → active=5 and pending=1. Next commit → active=7 and pending=0. wr_ch=5 or wr_sel=3 writes → no state change.
5. phase_sync mid-run on all channels, with commit the same cycle → acc=0 and new increments apply; wrap and phase_stb low that cycle. Then rst_n=0 for 1 cycle mid-run → every register and output 0.
6. PHASE_DITHER_EN: inc=0, offset=0 → phase_out equals the LFSR low 4 bits, matching a reference LFSR model with seed ACE1; acc stays 0.
